// File: rtl/flag_unit_if.sv
// Handshake and data bundle between the ALU adder, flag_unit and the branch logic.
// The master side feeds ALU results and consumes the decision; the slave side is flag_unit.
interface flag_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s;
    logic             c_msb;
    logic             c_out;
    logic             sub;
    logic             flag_we;
    logic [2:0]       cond;
    logic             out_valid;
    logic             out_ready;
    logic             take;
    logic             lt;
    logic             ltu;
    logic             z;
    logic             n;
    logic             v;
    logic             cf;

    modport master (
        output in_valid, s, c_msb, c_out, sub, flag_we, cond, out_ready,
        input  in_ready, out_valid, take, lt, ltu, z, n, v, cf
    );

    modport slave (
        input  in_valid, s, c_msb, c_out, sub, flag_we, cond, out_ready,
        output in_ready, out_valid, take, lt, ltu, z, n, v, cf
    );
endinterface

// File: rtl/flag_unit.sv
// Two-stage flag pipeline: stage 1 captures the raw ALU outputs, stage 2 holds the
// derived Z/N/V/C, signed/unsigned less-than and branch decision for one transaction.
// The architectural flag register only changes when a flag-writing result is consumed.
// Gate-level delay annotation is left to the simulation environment; cycle behaviour
// does not depend on it.
module flag_unit #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    flag_unit_if.slave bus
);

    localparam logic [2:0] COND_EQ  = 3'd0;
    localparam logic [2:0] COND_NE  = 3'd1;
    localparam logic [2:0] COND_LT  = 3'd2;
    localparam logic [2:0] COND_GE  = 3'd3;
    localparam logic [2:0] COND_LTU = 3'd4;
    localparam logic [2:0] COND_GEU = 3'd5;
    localparam logic [2:0] COND_AL  = 3'd6;
    localparam logic [2:0] COND_NV  = 3'd7;

    // stage 1 fields
    logic             s1_valid;
    logic [WIDTH-1:0] s1_s;
    logic             s1_c_msb;
    logic             s1_c_out;
    logic             s1_sub;
    logic             s1_flag_we;
    logic [2:0]       s1_cond;

    // stage 2 fields
    logic             s2_valid;
    logic             s2_z;
    logic             s2_n;
    logic             s2_v;
    logic             s2_cf;
    logic             s2_lt;
    logic             s2_ltu;
    logic             s2_take;
    logic             s2_flag_we;

    // architectural flags
    logic             r_z;
    logic             r_n;
    logic             r_v;
    logic             r_cf;

    logic             adv2;
    logic             s1_ready;
    logic             out_fire;

    logic             c_z;
    logic             c_n;
    logic             c_v;
    logic             c_cf;
    logic             c_lt;
    logic             c_ltu;
    logic             c_take;

    // Pipeline advance: stage 2 moves when empty or drained; stage 1 moves with it.
    // in_ready is held low while reset is asserted so nothing is accepted mid-reset.
    assign adv2     = ~s2_valid | bus.out_ready;
    assign s1_ready = ~s1_valid | adv2;
    assign out_fire = s2_valid & bus.out_ready;

    // Flag derivation and condition decode from the stage-1 snapshot.
    always_comb begin
        c_z   = &(~s1_s);
        c_n   = s1_s[WIDTH-1];
        c_v   = s1_c_msb ^ s1_c_out;
        c_cf  = s1_c_out;
        c_lt  = c_n ^ c_v;
        c_ltu = s1_sub & ~s1_c_out;
        c_take = 1'b0;
        case (s1_cond)
            COND_EQ:  c_take = c_z;
            COND_NE:  c_take = ~c_z;
            COND_LT:  c_take = c_lt;
            COND_GE:  c_take = ~c_lt;
            COND_LTU: c_take = c_ltu;
            COND_GEU: c_take = ~c_ltu;
            COND_AL:  c_take = 1'b1;
            COND_NV:  c_take = 1'b0;
            default:  c_take = 1'b0;
        endcase
    end

    // Stage 1: capture ALU outputs on an input handshake, hold while blocked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_s       <= '0;
            s1_c_msb   <= 1'b0;
            s1_c_out   <= 1'b0;
            s1_sub     <= 1'b0;
            s1_flag_we <= 1'b0;
            s1_cond    <= 3'd0;
        end else if (s1_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_s       <= bus.s;
                s1_c_msb   <= bus.c_msb;
                s1_c_out   <= bus.c_out;
                s1_sub     <= bus.sub;
                s1_flag_we <= bus.flag_we;
                s1_cond    <= bus.cond;
            end
        end
    end

    // Stage 2: register the derived results; frozen while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid   <= 1'b0;
            s2_z       <= 1'b0;
            s2_n       <= 1'b0;
            s2_v       <= 1'b0;
            s2_cf      <= 1'b0;
            s2_lt      <= 1'b0;
            s2_ltu     <= 1'b0;
            s2_take    <= 1'b0;
            s2_flag_we <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_z       <= c_z;
                s2_n       <= c_n;
                s2_v       <= c_v;
                s2_cf      <= c_cf;
                s2_lt      <= c_lt;
                s2_ltu     <= c_ltu;
                s2_take    <= c_take;
                s2_flag_we <= s1_flag_we;
            end
        end
    end

    // Architectural flags: commit only when a flag-writing result is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_z  <= 1'b0;
            r_n  <= 1'b0;
            r_v  <= 1'b0;
            r_cf <= 1'b0;
        end else if (out_fire && s2_flag_we) begin
            r_z  <= s2_z;
            r_n  <= s2_n;
            r_v  <= s2_v;
            r_cf <= s2_cf;
        end
    end

    assign bus.in_ready  = ~reset & s1_ready;
    assign bus.out_valid = s2_valid;
    assign bus.take      = s2_take;
    assign bus.lt        = s2_lt;
    assign bus.ltu       = s2_ltu;
    assign bus.z         = r_z;
    assign bus.n         = r_n;
    assign bus.v         = r_v;
    assign bus.cf        = r_cf;

endmodule
